// File: rtl/onehot_scan_decoder_pkg.sv
// onehot_scan_pkg: shared encodings for the one-hot scan decoder.
//   mode_e  : values of the 2-bit mode input.
//   state_e : controller states.
//   onehot_w: output width for a given select width.
package onehot_scan_pkg;

  typedef enum logic [1:0] {
    MODE_DECODE    = 2'b00,
    MODE_SCAN_UP   = 2'b01,
    MODE_SCAN_DOWN = 2'b10,
    MODE_CLEAR     = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DEC  = 2'd1,
    SCAN = 2'd2
  } state_e;

  function automatic int onehot_w(input int n_sel);
    return (n_sel < 1) ? 1 : (1 << n_sel);
  endfunction

endpackage

// File: rtl/onehot_scan_decoder_if.sv
// onehot_scan_decoder_if: control/handshake bundle of the scan decoder.
//   master: en, mode, in_valid, sel, dwell out; in_ready, o, o_valid, idx, wrap in.
//   slave : the decoder side (mirror of master).
interface onehot_scan_decoder_if
  import onehot_scan_pkg::*;
#(
  parameter int N_SEL   = 3,
  parameter int DWELL_W = 8
);
  localparam int OUT_W = onehot_w(N_SEL);

  logic               en;
  logic [1:0]         mode;
  logic               in_valid;
  logic               in_ready;
  logic [N_SEL-1:0]   sel;
  logic [DWELL_W-1:0] dwell;
  logic [OUT_W-1:0]   o;
  logic               o_valid;
  logic [N_SEL-1:0]   idx;
  logic               wrap;

  modport master (
    output en, mode, in_valid, sel, dwell,
    input  in_ready, o, o_valid, idx, wrap
  );

  modport slave (
    input  en, mode, in_valid, sel, dwell,
    output in_ready, o, o_valid, idx, wrap
  );
endinterface

// File: rtl/onehot_scan_decoder_dec.sv
// onehot_dec: purely combinational N_SEL -> 2**N_SEL one-hot decoder.
//   idx    : binary index
//   onehot : single bit set at position idx
module onehot_dec
  import onehot_scan_pkg::*;
#(
  parameter int N_SEL = 3,
  localparam int OUT_W = onehot_w(N_SEL)
) (
  input  logic [N_SEL-1:0] idx,
  output logic [OUT_W-1:0] onehot
);

  always_comb begin
    onehot      = '0;
    onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/onehot_scan_decoder.sv
// onehot_scan_decoder: registered binary-to-one-hot decoder with a
// valid/ready load port and an autonomous walking-one scan mode.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : slave side of onehot_scan_decoder_if
//          in : en, mode, in_valid, sel, dwell
//          out: in_ready, o (one-hot or zero), o_valid, idx, wrap (pulse)
module onehot_scan_decoder
  import onehot_scan_pkg::*;
#(
  parameter int N_SEL   = 3,
  parameter int DWELL_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  onehot_scan_decoder_if.slave  bus
);

  localparam int OUT_W = onehot_w(N_SEL);

  state_e             state_q, state_d;
  logic [N_SEL-1:0]   idx_q, idx_d;
  logic               o_valid_q, o_valid_d;
  logic               wrap_q, wrap_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0]   o_q, o_d;
  logic [OUT_W-1:0]   onehot_nxt;

  mode_e mode;
  logic  accept;

  assign mode        = mode_e'(bus.mode);
  // Ready never looks at in_valid, so a source may wait on it safely.
  assign bus.in_ready = bus.en & ~rst & (mode != MODE_CLEAR);
  assign accept       = bus.in_valid & bus.in_ready;

  // Next-state / datapath. Priority: en=0 freeze, CLEAR, accept, scan step.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    o_valid_d = o_valid_q;
    dwell_d   = dwell_q;
    cnt_d     = cnt_q;
    wrap_d    = 1'b0;

    if (bus.en) begin
      if (mode == MODE_CLEAR) begin
        state_d   = IDLE;
        idx_d     = '0;
        o_valid_d = 1'b0;
      end else if (accept) begin
        // An accept overrides any step that would have been due this cycle.
        idx_d     = bus.sel;
        o_valid_d = 1'b1;
        if (mode == MODE_DECODE) begin
          state_d = DEC;
        end else begin
          state_d = SCAN;
          dwell_d = bus.dwell;
          cnt_d   = bus.dwell;
        end
      end else if (state_q == SCAN) begin
        if (mode == MODE_DECODE) begin
          // Freeze in place: o and the counter keep their values.
          state_d = DEC;
        end else if (cnt_q == '0) begin
          // Direction is taken from the live mode, so UP/DOWN swaps
          // apply at the next step without disturbing idx or count.
          cnt_d = dwell_q;
          if (mode == MODE_SCAN_UP) begin
            idx_d  = idx_q + 1'b1;
            wrap_d = (idx_q == {N_SEL{1'b1}});
          end else begin
            idx_d  = idx_q - 1'b1;
            wrap_d = (idx_q == '0);
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    end
  end

  onehot_dec #(.N_SEL(N_SEL)) u_dec (
    .idx    (idx_d),
    .onehot (onehot_nxt)
  );

  // Output stays all-zero unless a valid index is held.
  assign o_d = o_valid_d ? onehot_nxt : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      o_valid_q <= 1'b0;
      wrap_q    <= 1'b0;
      dwell_q   <= '0;
      cnt_q     <= '0;
      o_q       <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      o_valid_q <= o_valid_d;
      wrap_q    <= wrap_d;
      dwell_q   <= dwell_d;
      cnt_q     <= cnt_d;
      o_q       <= o_d;
    end
  end

  assign bus.o       = o_q;
  assign bus.o_valid = o_valid_q;
  assign bus.idx     = idx_q;
  assign bus.wrap    = wrap_q;

endmodule

// File: tb/tb_onehot_scan_decoder.sv
// tb_onehot_scan_decoder: drives N_SEL=1,3,5 decoders with one shared
// stimulus stream and checks every cycle against a hold-time model.
module tb_onehot_scan_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, in_valid;
  logic [1:0] mode;
  logic [4:0] rs;
  logic [7:0] dwell;

  always #5 clk = ~clk;

  onehot_scan_decoder_if #(.N_SEL(1), .DWELL_W(8)) b1();
  onehot_scan_decoder_if #(.N_SEL(3), .DWELL_W(8)) b3();
  onehot_scan_decoder_if #(.N_SEL(5), .DWELL_W(8)) b5();

  assign b1.en = en;  assign b1.mode = mode;  assign b1.in_valid = in_valid;
  assign b3.en = en;  assign b3.mode = mode;  assign b3.in_valid = in_valid;
  assign b5.en = en;  assign b5.mode = mode;  assign b5.in_valid = in_valid;
  assign b1.dwell = dwell;  assign b3.dwell = dwell;  assign b5.dwell = dwell;
  assign b1.sel = rs[0:0];  assign b3.sel = rs[2:0];  assign b5.sel = rs;

  onehot_scan_decoder #(.N_SEL(1), .DWELL_W(8)) u_dut1 (.clk(clk), .rst(rst), .bus(b1));
  onehot_scan_decoder #(.N_SEL(3), .DWELL_W(8)) u_dut3 (.clk(clk), .rst(rst), .bus(b3));
  onehot_scan_decoder #(.N_SEL(5), .DWELL_W(8)) u_dut5 (.clk(clk), .rst(rst), .bus(b5));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: index held, whether scanning, cycles left on this index,
  // and cycles per index (dwell+1).
  int W[3] = '{2, 8, 32};
  bit m_val[3], m_scan[3], m_wrap[3];
  int m_idx[3], m_left[3], m_per[3];

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_val[k] = 0; m_scan[k] = 0; m_wrap[k] = 0;
      m_idx[k] = 0; m_left[k] = 0; m_per[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      int s;
      s = int'(rs) % W[k];
      m_wrap[k] = 0;
      if (en) begin
        if (mode == 2'd3) begin
          m_val[k] = 0; m_scan[k] = 0; m_idx[k] = 0;
        end else if (in_valid) begin
          m_val[k]  = 1;
          m_idx[k]  = s;
          m_scan[k] = (mode != 2'd0);
          if (mode != 2'd0) begin
            m_per[k]  = int'(dwell) + 1;
            m_left[k] = int'(dwell) + 1;
          end
        end else if (m_scan[k]) begin
          if (mode == 2'd0) m_scan[k] = 0;
          else begin
            m_left[k]--;
            if (m_left[k] == 0) begin
              m_left[k] = m_per[k];
              if (mode == 2'd1) begin
                m_wrap[k] = (m_idx[k] == W[k] - 1);
                m_idx[k]  = (m_idx[k] + 1) % W[k];
              end else begin
                m_wrap[k] = (m_idx[k] == 0);
                m_idx[k]  = (m_idx[k] + W[k] - 1) % W[k];
              end
            end
          end
        end
      end
    end
  endtask

  task automatic get(input int k, output logic [31:0] o, output logic v,
                     output logic [31:0] ix, output logic w, output logic r);
    case (k)
      0: begin o = 32'(b1.o); v = b1.o_valid; ix = 32'(b1.idx); w = b1.wrap; r = b1.in_ready; end
      1: begin o = 32'(b3.o); v = b3.o_valid; ix = 32'(b3.idx); w = b3.wrap; r = b3.in_ready; end
      default: begin o = 32'(b5.o); v = b5.o_valid; ix = 32'(b5.idx); w = b5.wrap; r = b5.in_ready; end
    endcase
  endtask

  task automatic compare(input string tag);
    logic [31:0] o, ix;
    logic v, w, r;
    for (int k = 0; k < 3; k++) begin
      get(k, o, v, ix, w, r);
      chk($sformatf("%s.o%0d", tag, k), o, m_val[k] ? (32'd1 << m_idx[k]) : 32'd0);
      chk($sformatf("%s.vld%0d", tag, k), 32'(v), 32'(m_val[k]));
      chk($sformatf("%s.idx%0d", tag, k), ix, 32'(m_idx[k]));
      chk($sformatf("%s.wrap%0d", tag, k), 32'(w), 32'(m_wrap[k]));
    end
  endtask

  // One clock: check ready, advance model, clock, check outputs at negedge.
  task automatic cyc(input string tag);
    logic [31:0] o, ix;
    logic v, w, r;
    #1;
    for (int k = 0; k < 3; k++) begin
      get(k, o, v, ix, w, r);
      chk($sformatf("%s.rdy%0d", tag, k), 32'(r), 32'(en & ~rst & (mode != 2'd3)));
    end
    if (rst) model_reset();
    else     model_step();
    @(posedge clk);
    @(negedge clk);
    compare(tag);
  endtask

  logic [31:0] exp_up[8]  = '{32'h40, 32'h40, 32'h40, 32'h80, 32'h80, 32'h80, 32'h01, 32'h01};
  logic        wrp_up[8]  = '{0, 0, 0, 0, 0, 0, 1, 0};
  logic [31:0] exp_dn[4]  = '{32'h02, 32'h01, 32'h80, 32'h40};
  logic        wrp_dn[4]  = '{0, 0, 1, 0};

  initial begin
    rst = 1'b1; en = 1'b0; in_valid = 1'b0; mode = 2'd0; rs = '0; dwell = '0;
    model_reset();
    cyc("rst");
    cyc("rst");
    rst = 1'b0;

    // Decode sweep: 1-cycle latency, one bit per sel.
    en = 1'b1; mode = 2'd0; in_valid = 1'b1;
    for (int s = 0; s < 8; s++) begin
      rs = 5'(s);
      cyc("dec");
      chk("dec_sweep", 32'(b3.o), 32'd1 << s);
    end

    // Asynchronous reset takes effect without a clock edge.
    rst = 1'b1;
    #1;
    chk("arst_o", 32'(b3.o), 32'd0);
    chk("arst_vld", 32'(b3.o_valid), 32'd0);
    chk("arst_idx", 32'(b3.idx), 32'd0);
    chk("arst_rdy", 32'(b3.in_ready), 32'd0);
    model_reset();
    cyc("arst");
    rst = 1'b0;

    // SCAN_UP from 6 with dwell 2: three cycles per index, wrap into 0.
    mode = 2'd1; rs = 5'd6; dwell = 8'd2; in_valid = 1'b1;
    cyc("up");
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) cyc("up");
      chk("up_o", 32'(b3.o), exp_up[i]);
      chk("up_wrap", 32'(b3.wrap), 32'(wrp_up[i]));
    end

    // SCAN_DOWN from 1 with dwell 0: step every cycle, wrap into 7.
    mode = 2'd2; rs = 5'd1; dwell = 8'd0; in_valid = 1'b1;
    cyc("dn");
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) cyc("dn");
      chk("dn_o", 32'(b3.o), exp_dn[i]);
      chk("dn_wrap", 32'(b3.wrap), 32'(wrp_dn[i]));
    end

    // en drop with two hold cycles still owed: frozen, then exactly 2 to step.
    mode = 2'd1; rs = 5'd0; dwell = 8'd3; in_valid = 1'b1;
    cyc("en");
    in_valid = 1'b0;
    cyc("en");
    cyc("en");
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc("en_off");
      chk("frz_o", 32'(b3.o), 32'h01);
      chk("frz_wrap", 32'(b3.wrap), 32'd0);
    end
    en = 1'b1;
    cyc("en_on");
    chk("resume_hold", 32'(b3.o), 32'h01);
    cyc("en_on");
    chk("resume_step", 32'(b3.o), 32'h02);

    // CLEAR blocks ready even with in_valid high, and empties the output.
    mode = 2'd3; in_valid = 1'b1;
    #1;
    chk("clr_rdy", 32'(b3.in_ready), 32'd0);
    cyc("clr");
    chk("clr_o", 32'(b3.o), 32'd0);
    chk("clr_vld", 32'(b3.o_valid), 32'd0);

    // Accept on a cycle where a wrapping step is due: accept wins.
    mode = 2'd1; rs = 5'd7; dwell = 8'd0; in_valid = 1'b1;
    cyc("prio");
    chk("prio_pre", 32'(b3.o), 32'h80);
    rs = 5'd3;
    cyc("prio");
    chk("prio_o", 32'(b3.o), 32'h08);
    chk("prio_wrap", 32'(b3.wrap), 32'd0);

    // DECODE without accept freezes the scan; SCAN mode alone does not restart it.
    in_valid = 1'b0; mode = 2'd0;
    cyc("frz");
    chk("dfrz_o", 32'(b3.o), 32'h08);
    mode = 2'd1;
    cyc("frz");
    chk("dfrz_hold", 32'(b3.o), 32'h08);

    // Random streams across all three widths.
    for (int i = 0; i < 3000; i++) begin
      int r;
      rst      = ($urandom_range(0, 199) == 0);
      en       = ($urandom_range(0, 9) != 0);
      r        = $urandom_range(0, 9);
      mode     = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      in_valid = ($urandom_range(0, 3) == 0);
      rs       = 5'($urandom);
      dwell    = 8'($urandom_range(0, 3));
      cyc("rnd");
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/onehot_scan_decoder.md
Name: onehot_scan_decoder

Overview:
Parametrised, registered binary-to-one-hot decoder. It generalises the 3-to-8 combinational decoder to N_SEL select bits and adds three things: a valid/ready input handshake, a registered output with a valid flag, and an autonomous walking-one scan mode with programmable dwell. It drives row/channel enables such as display multiplexing, chip-select fan-out and channel sequencing, and sits between control logic and the enable lines.

Parameters:
N_SEL, 3, select width; output width OUT_W = 2**N_SEL is a derived localparam (minimum 1).
DWELL_W, 8, width of the dwell (cycles-per-step) field.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
en  input  1  global enable; 0 freezes all state and outputs
mode  input  2  00 DECODE, 01 SCAN_UP, 10 SCAN_DOWN, 11 CLEAR
in_valid  input  1  sel/dwell offered
in_ready  output  1  block accepts sel/dwell this cycle
sel  input  N_SEL  index to decode; start index in scan modes
dwell  input  DWELL_W  scan step period minus one, captured on accept
o  output  OUT_W  registered one-hot output, all-zero when idle
o_valid  output  1  o holds a valid one-hot value
idx  output  N_SEL  binary index of the active bit in o
wrap  output  1  one-cycle pulse when scan wraps around

Behaviour:
- Reset (asynchronous, any time including mid-scan):
  - state=IDLE; o=0, o_valid=0, idx=0, wrap=0.
  - Dwell register=0, dwell counter=0.
  - in_ready is 0 while rst is high.
- in_ready = en & ~rst & (mode != CLEAR). It is combinational and independent of in_valid.
- Accept = in_valid & in_ready.
- States: IDLE, DEC, SCAN.
- IDLE:
  - o=0, o_valid=0.
  - Accept with mode DECODE -> DEC.
  - Accept with mode SCAN_* -> SCAN.
- DEC:
  - On accept, the next cycle has o = 1<<sel, idx=sel, o_valid=1. Latency is 1 cycle.
  - o holds until the next accept; back-to-back accepts update every cycle.
- SCAN:
  - On accept, the next cycle has o = 1<<sel, idx=sel, and the dwell register and counter are loaded with dwell.
  - Each cycle the counter decrements. When it reads 0, idx steps and the counter reloads from the dwell register. Each index is therefore held for dwell+1 cycles.
  - SCAN_UP: idx+1 modulo OUT_W. SCAN_DOWN: idx-1 modulo OUT_W.
  - wrap=1 for exactly the cycle o moves from OUT_W-1 to 0 (UP) or from 0 to OUT_W-1 (DOWN).
  - dwell=0 steps every cycle.
- Mode changes:
  - A change between SCAN_UP and SCAN_DOWN while in SCAN changes direction at the next step without reloading idx or the counter.
  - Mode DECODE while in SCAN, with no accept: o freezes at its current value, state -> DEC, counter is held.
  - An accept in SCAN with mode SCAN_* restarts the scan from the new sel and dwell. If a step was due that same cycle, the accept wins.
- CLEAR (mode 11, en=1): next cycle state=IDLE, o=0, o_valid=0, idx=0, wrap=0. CLEAR takes priority over everything except rst.
- en=0:
  - State, o, idx, o_valid and the counter all freeze; wrap is forced to 0.
  - Accepts are impossible because in_ready=0.
  - Scanning resumes with the remaining count when en returns.
- Invariants:
  - o is always either all-zero (o_valid=0) or exactly one-hot (o_valid=1).
  - o == (1<<idx) whenever o_valid=1.
- Width rules:
  - idx arithmetic wraps naturally in N_SEL bits.
  - The counter is DWELL_W bits and unsigned, with no overflow path.

Decomposition:
- Package onehot_scan_pkg holds:
  - mode encodings MODE_DECODE, MODE_SCAN_UP, MODE_SCAN_DOWN, MODE_CLEAR;
  - the state enum (IDLE, DEC, SCAN).
- Sub-module onehot_dec: a purely combinational N_SEL -> 2**N_SEL one-hot decoder, instantiated on the next-idx path. The output register sits in the parent.

Test Plan:
- Reset/decode sweep: assert rst mid-run -> o=0, o_valid=0, idx=0 immediately. Then, with N_SEL=3, mode=DECODE, accept sel=0..7 on consecutive cycles -> the following cycles show o=8'h01,02,04,...,80 with o_valid=1.
- SCAN_UP, sel=6, dwell=2 -> o=8'h40 for 3 cycles, then 8'h80 for 3, then 8'h01 with wrap=1 on the first cycle of 8'h01 only.
- SCAN_DOWN, sel=1, dwell=0 -> o=02,01,80,40 on successive cycles, with wrap=1 on the 80 cycle.
- In SCAN_UP with dwell=3, drop en for 5 cycles one cycle into dwell -> o, idx and the count frozen, wrap=0. After en returns, o steps after exactly 2 more cycles.
- Handshake/priority: with in_valid=1 and mode=CLEAR -> in_ready=0, next cycle o=0, o_valid=0. In SCAN, an accept of sel=3 on the cycle a step is due -> o=8'h08, with no step and no wrap.
- Parameter sweep: N_SEL=1 and N_SEL=5, random accept/mode/en/rst streams -> one-hot invariant holds, o==(1<<idx) whenever o_valid=1, and wrap occurs only on boundary crossings.
